ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, RAM address width.
REQ-002 SHALL have parameter DW, default 8, RAM data width; requester count is fixed at 4.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-requester access request, bit i = requester i.
REQ-006 SHALL have port we  input  4  per-requester write (1) / read (0) qualifier.
REQ-007 SHALL have port addr  input  4*AW  packed addresses, slice i = [i*AW +: AW].
REQ-008 SHALL have port wdata  input  4*DW  packed write data, slice i = [i*DW +: DW].
REQ-009 SHALL have port lock  input  4  per-requester grant-hold request (used only with ARB_LOCK_EN).
REQ-010 SHALL have port gnt  output  4  one-hot combinational accept; request i is consumed in any cycle where req[i] and gnt[i] are both 1.
REQ-011 SHALL have port rvalid  output  1  read-return strobe, one cycle per accepted read.
REQ-012 SHALL have port rid  output  2  index of the requester owning the rdata value.
REQ-013 SHALL have port rdata  output  DW  read data, equal to ram_q.
REQ-014 SHALL have port ram_addr  output  AW  registered address to one port of the dual-port RAM.
REQ-015 SHALL have port ram_data  output  DW  registered write data to the RAM.
REQ-016 SHALL have port ram_we  output  1  registered write enable to the RAM.
REQ-017 SHALL have port ram_q  input  DW  RAM read data, valid one clock after the RAM samples a read.

Function
REQ-018 SHALL grant at most one requester per cycle and SHALL assert gnt[i] only when req[i]=1.
REQ-019 SHALL use round-robin priority: the search starts at (last granted index + 1) mod 4; after reset it starts at 0.
REQ-020 SHALL accept one request every cycle, with no idle cycle between back-to-back grants.
REQ-021 SHALL, at the edge ending grant cycle T, register the winner's addr, wdata and we into ram_addr, ram_data and ram_we; these are valid throughout T+1.
REQ-022 SHALL drive ram_we=0 in any cycle following a cycle with no grant, and SHALL hold ram_addr and ram_data at their previous values.
REQ-023 SHALL track read commands through a 2-stage valid/tag pipeline: stage 1 = command on the RAM bus (T+1); stage 2 = return (T+2).
REQ-024 SHALL assert rvalid=1 with rid=i and rdata=ram_q during T+2 for a read granted to requester i in T; writes produce no rvalid.
REQ-025 SHALL return read data that reflects a write granted in an earlier cycle, including a write granted in cycle T-1 to the same address.
REQ-026 SHALL, when req falls without a grant, drop the request with no side effect; requesters hold req, we, addr and wdata stable until granted.
REQ-027 SHALL implement arbiter states IDLE (no grant), GRANT (grant given, pointer advances) and LOCKED (ARB_LOCK_EN only).
REQ-028 SHALL transition IDLE->GRANT on any req, GRANT->IDLE on no req, and GRANT->GRANT on continued req.

Reset
REQ-029 SHALL, while reset_n=0, force gnt=0, rvalid=0, rid=0, ram_we=0, ram_addr=0, ram_data=0, priority pointer=0, state=IDLE, and clear all pipeline valids.
REQ-030 SHALL discard any command or read in flight when reset is asserted mid-operation, and SHALL produce no rvalid for it after release.
REQ-031 SHALL make its first grant possible in the first cycle after reset_n rises.

Configuration
REQ-032 SHALL, with ARB_LOCK_EN defined, enter LOCKED after granting i while lock[i]=1; in LOCKED it SHALL grant only i while req[i]=1 and SHALL return to round-robin (pointer=i+1) when lock[i]=0 or req[i]=0.
REQ-033 SHALL, without ARB_LOCK_EN, ignore the lock input, omit the LOCKED state, and be strictly round-robin.

Verification
REQ-034 SHALL verify: req=4'b1111 held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3 with one grant per cycle.
REQ-035 SHALL verify: requester 2 writes 8'hA5 to addr 6'd10 in cycle T, requester 0 reads addr 10 in T+1 -> rvalid=1, rid=0, rdata=8'hA5 in T+3.
REQ-036 SHALL verify: single read by requester 3 granted in T -> ram_we=0 and ram_addr valid in T+1, rvalid in T+2 only, rvalid=0 in T+3.
REQ-037 SHALL verify: reset_n pulsed low in T+1 after a read grant in T -> no rvalid, all outputs 0, and the next grant goes to the lowest active requester from index 0.
REQ-038 SHALL verify: with ARB_LOCK_EN, req=4'b0011 and lock[1]=1 for 4 cycles -> gnt[1] for 4 cycles; after lock drops -> next grant is 0.
REQ-039 SHALL verify: req=0 for 3 cycles -> gnt=0 and ram_we=0 while ram_addr holds its last value.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Four-requester round-robin arbiter driving one port of a synchronous RAM.
// Optional grant hold via `ARB_LOCK_EN`; reads return two cycles after grant.
module ram_port_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [3:0]      req,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] addr,
    input  logic [4*DW-1:0] wdata,
    input  logic [3:0]      lock,
    output logic [3:0]      gnt,
    output logic            rvalid,
    output logic [1:0]      rid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_data,
    output logic            ram_we,
    input  logic [DW-1:0]   ram_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef ARB_LOCK_EN
        GRANT  = 2'd1,
        LOCKED = 2'd2
`else
        GRANT  = 2'd1
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      win;
    logic [1:0]      idx;
    logic            hit;
    logic [AW-1:0]   ram_addr_q;
    logic [DW-1:0]   ram_data_q;
    logic            ram_we_q;
    logic            s1_v_q, s2_v_q;
    logic [1:0]      s1_id_q, s2_id_q;
`ifdef ARB_LOCK_EN
    logic [1:0]      own_q;
`else
    logic            unused_cfg;
    assign unused_cfg = ^{lock, state_q};
`endif

    always_comb begin
        hit = 1'b0;
        win = ptr_q;
        idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
`ifdef ARB_LOCK_EN
        // Holder keeps the port while it both requests and locks.
        if (state_q == LOCKED && req[own_q] && lock[own_q]) begin
            hit = 1'b1;
            win = own_q;
        end
        state_d = hit ? (lock[win] ? LOCKED : GRANT) : IDLE;
`else
        state_d = hit ? GRANT : IDLE;
`endif
        ptr_d = hit ? win + 2'd1 : ptr_q;
        gnt   = (hit && reset_n) ? (4'b0001 << win) : 4'b0000;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_id_q    <= 2'd0;
            s2_v_q     <= 1'b0;
            s2_id_q    <= 2'd0;
`ifdef ARB_LOCK_EN
            own_q      <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ram_we_q <= hit & we[win];
            s1_v_q   <= hit & ~we[win];
            s1_id_q  <= win;
            s2_v_q   <= s1_v_q;
            s2_id_q  <= s1_id_q;
            if (hit) begin
                ram_addr_q <= addr[win*AW +: AW];
                ram_data_q <= wdata[win*DW +: DW];
            end
`ifdef ARB_LOCK_EN
            if (hit) begin
                own_q <= win;
            end
`endif
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;
    assign ram_we   = ram_we_q;
    assign rvalid   = s2_v_q;
    assign rid      = s2_id_q;
    assign rdata    = ram_q;

endmodule
